// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
// ALUctrl imports the same ALUOp constants from here.
package mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC     = 4'd7,
    ST_ALU_WB   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_ADDI_EX  = 4'd11,
    ST_ADDI_WB  = 4'd12,
    ST_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_IDLE  = 3'b101;

  // Datapath control bundle driven by the sequencer.
  typedef struct packed {
    logic               pc_en;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of sequencer state (plus zero / mem_ready) into the
// datapath control bundle.
module mc_ctrl_outdec
  import mc_pkg::*;
(
  input  state_t i_state,
  input  logic   i_zero,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.alu_op = ALUOP_IDLE;
    case (i_state)
      ST_FETCH: begin
        // PC and IR update only on the completing cycle, so PC moves once per fetch.
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = 2'b01;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_en     = i_mem_ready;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = 2'b11;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_source = 2'b01;
        o_ctrl.pc_en     = i_zero;
      end
      ST_JUMP: begin
        o_ctrl.pc_source = 2'b10;
        o_ctrl.pc_en     = 1'b1;
      end
      ST_ADDI_WB: o_ctrl.reg_write  = 1'b1;
      ST_ILLEGAL: o_ctrl.illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control sequencer: state register and next-state logic.
// Optional performance counters enabled with MC_CTRL_PERF_EN.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     w_next = ST_FETCH;
      ST_FETCH:    if (mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = ST_EXEC;
          OP_LW, OP_SW: w_next = ST_MEM_ADDR;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
          OP_ADDI:      w_next = ST_ADDI_EX;
          default:      w_next = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR: w_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) w_next = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready) w_next = ST_FETCH;
      ST_EXEC:     w_next = ST_ALU_WB;
      ST_ADDI_EX:  w_next = ST_ADDI_WB;
      ST_MEM_WB, ST_ALU_WB, ST_ADDI_WB,
      ST_BRANCH, ST_JUMP, ST_ILLEGAL:
                   w_next = ST_FETCH;
      default:     w_next = ST_IDLE;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_zero      (zero),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign pc_en      = w_ctrl.pc_en;
  assign iord       = w_ctrl.iord;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign ir_write   = w_ctrl.ir_write;
  assign reg_write  = w_ctrl.reg_write;
  assign reg_dst    = w_ctrl.reg_dst;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign pc_source  = w_ctrl.pc_source;
  assign alu_op     = w_ctrl.alu_op;
  assign illegal_op = w_ctrl.illegal_op;
  assign state_dbg  = STATE_W'(r_state);

`ifdef MC_CTRL_PERF_EN
  logic             w_retire;
  logic             w_stall;
  logic [CNT_W-1:0] r_instr_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // An instruction retires when a completing state hands back to FETCH; ILLEGAL never retires.
  assign w_retire = (w_next == ST_FETCH) &&
                    (r_state inside {ST_MEM_WB, ST_ALU_WB, ST_ADDI_WB,
                                     ST_MEM_WR, ST_BRANCH, ST_JUMP});
  assign w_stall  = !mem_ready && (r_state inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      if (w_stall)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction step lists checked every
// cycle against a rule-based model, plus literal spot checks.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  mc_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
`ifdef MC_CTRL_PERF_EN
    ,
    .instr_cnt  (instr_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         st;
    logic [5:0] op;
    logic       z;
    logic       mr;
  } item_t;

  item_t       q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [20:0] exp_vec;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_ic, exp_sc;
  int          m_ic = 0;
  int          m_sc = 0;
  logic [5:0]  cur_op;
  logic        cur_z;

  wire [20:0] act_vec = {state_dbg, pc_en, iord, mem_read, mem_write, ir_write,
                         reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                         pc_source, alu_op, illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected state code and outputs for one step, straight from the step descriptions.
  function automatic logic [20:0] model(input int st, input logic z, input logic mr);
    logic pe, io, rd_m, wr_m, irw, rw, rdst, m2r, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] aop;
    {pe, io, rd_m, wr_m, irw, rw, rdst, m2r, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; aop = 3'b101;
    case (st)
      1:  begin rd_m = 1; sb = 2'b01; aop = 3'b000; irw = mr; pe = mr; end
      2:  begin sb = 2'b11; aop = 3'b000; end
      3:  begin sa = 1; sb = 2'b10; aop = 3'b000; end
      4:  begin rd_m = 1; io = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin wr_m = 1; io = 1; end
      7:  begin sa = 1; aop = 3'b010; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin sa = 1; aop = 3'b001; ps = 2'b01; pe = z; end
      10: begin ps = 2'b10; pe = 1; end
      11: begin sa = 1; sb = 2'b10; aop = 3'b000; end
      12: rw = 1;
      13: ill = 1;
      default: ;
    endcase
    return {4'(st), pe, io, rd_m, wr_m, irw, rw, rdst, m2r, sa, sb, ps, aop, ill};
  endfunction

  task automatic add(input int st, input logic mr);
    item_t it;
    it.st = st; it.op = cur_op; it.z = cur_z; it.mr = mr;
    q.push_back(it);
  endtask

  // Step list of one instruction: fetch with fs stall cycles, then per-opcode steps.
  task automatic build(input logic [5:0] op, input logic z, input int fs, input int ms);
    cur_op = op;
    cur_z  = z;
    for (int i = 0; i < fs; i++) add(1, 1'b0);
    add(1, 1'b1);
    add(2, 1'($urandom_range(0, 1)));
    case (op)
      6'b000000: begin add(7, 1'($urandom_range(0, 1))); add(8, 1'($urandom_range(0, 1))); end
      6'b100011: begin
        add(3, 1'($urandom_range(0, 1)));
        for (int i = 0; i < ms; i++) add(4, 1'b0);
        add(4, 1'b1);
        add(5, 1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        add(3, 1'($urandom_range(0, 1)));
        for (int i = 0; i < ms; i++) add(6, 1'b0);
        add(6, 1'b1);
      end
      6'b000100: add(9, 1'($urandom_range(0, 1)));
      6'b000010: add(10, 1'($urandom_range(0, 1)));
      6'b001000: begin add(11, 1'($urandom_range(0, 1))); add(12, 1'($urandom_range(0, 1))); end
      default:   add(13, 1'($urandom_range(0, 1)));
    endcase
  endtask

  // Drive each step for one cycle; leaves the last step's inputs applied.
  task automatic play();
    item_t it;
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clk);
      opcode = it.op; zero = it.z; mem_ready = it.mr;
      exp_vec = model(it.st, it.z, it.mr);
      exp_ic = 32'(m_ic);
      exp_sc = 32'(m_sc);
      exp_valid = 1'b1;
      if ((it.st == 1 || it.st == 4 || it.st == 6) && !it.mr) m_sc++;
      if (it.st == 5 || it.st == 8 || it.st == 12 || it.st == 9 || it.st == 10 ||
          (it.st == 6 && it.mr)) m_ic++;
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      check("cycle_outputs", 32'(act_vec), 32'(exp_vec));
`ifdef MC_CTRL_PERF_EN
      check("instr_cnt", instr_cnt, exp_ic);
      check("stall_cnt", stall_cnt, exp_sc);
`endif
    end
  end

  task automatic idle_cycles();
    @(negedge clk);
    exp_vec = model(0, 1'b0, 1'b0);
    exp_ic = 0; exp_sc = 0;
    exp_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_aluop", 32'(alu_op), 32'b101);
    idle_cycles();

    build(6'b000000, 1'b0, 0, 0); play(); #3;
    check("rtype_wb_regdst", 32'({reg_write, reg_dst}), 32'b11);

    build(6'b100011, 1'b0, 2, 0); play(); #3;
    check("lw_wb_memtoreg", 32'(mem_to_reg), 32'd1);

    build(6'b000100, 1'b1, 0, 0); play(); #3;
    check("beq_taken_pc", 32'({pc_en, pc_source, alu_op}), 32'b1_01_001);

    build(6'b000100, 1'b0, 0, 0); play(); #3;
    check("beq_not_taken_pcen", 32'(pc_en), 32'd0);

    build(6'b101011, 1'b0, 0, 3); play(); #3;
    check("sw_wr_iord", 32'({mem_write, iord}), 32'b11);

    build(6'b000010, 1'b0, 1, 0); play(); #3;
    check("j_pc", 32'({pc_en, pc_source}), 32'b1_10);

    build(6'b001000, 1'b0, 0, 0);
    build(6'b100011, 1'b0, 0, 1);
    build(6'b000000, 1'b0, 1, 0);
    build(6'b111111, 1'b0, 0, 0); play(); #3;
    check("illegal_pulse", 32'({state_dbg, illegal_op}), 32'b1101_1);

    build(6'b000011, 1'b1, 0, 0);
    build(6'b000000, 1'b0, 0, 0);
    void'(q.pop_back());
    play(); #3;
    check("exec_aluop", 32'(alu_op), 32'b010);

    // Abort mid-EXEC: reset must take effect without waiting for a clock edge.
    exp_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_vec", 32'(act_vec), 32'(model(0, 1'b0, 1'b0)));
    m_ic = 0; m_sc = 0;
    idle_cycles();

    build(6'b000000, 1'b0, 0, 0);
    build(6'b101011, 1'b0, 2, 2);
    build(6'b000010, 1'b0, 0, 0);
    play();

    @(negedge clk);
    exp_valid = 1'b0;
    #5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
